magma_key_sched: RTL and testbench

Round-key reader for the Magma (GOST 28147-89) datapath. The 256-bit cipher key is loaded as eight 32-bit words into the `key` store by its writer. This block is the read side of that store: on `start` it issues one read per round to the `key` store, in the Magma schedule order for encryption or decryption. It presents each fetched word to the round engine over a valid/ready handshake, tagged with its round number.

---
 rtl/magma_pkg.sv | 26 ++
 rtl/magma_round_idx.sv | 12 +
 rtl/magma_key_sched.sv | 180 ++++++++++++++++++
 tb/tb_magma_key_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/magma_pkg.sv
// Shared types, round constants and the Magma round-key word index for the key scheduler.
package magma_pkg;

  localparam int ROUNDS         = 32;
  localparam int KEY_WORDS      = 8;
  localparam int ENC_FWD_ROUNDS = 24;
  localparam int DEC_FWD_ROUNDS = 8;

  localparam logic [5:0] KEY_BASE = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

  // Forward rounds use K(r mod 8); the reversed tail uses K(7 - r mod 8), i.e. the bitwise inverse.
  function automatic logic [2:0] key_idx(input logic [4:0] round, input logic decrypt);
    logic fwd;
    fwd = decrypt ? (round < 5'(DEC_FWD_ROUNDS)) : (round < 5'(ENC_FWD_ROUNDS));
    return fwd ? round[2:0] : ~round[2:0];
  endfunction

endpackage

// File: rtl/magma_round_idx.sv
// Combinational round/mode to key-word index; also reused by the round engine self-check.
module magma_round_idx
  import magma_pkg::*;
(
  input  logic [4:0] round_i,
  input  logic       decrypt_i,
  output logic [2:0] idx_o
);

  assign idx_o = key_idx(round_i, decrypt_i);

endmodule

// File: rtl/magma_key_sched.sv
// Magma round-key reader: fetches one key-store word per round and hands it out over valid/ready.
// Build option KEY_SCHED_PREFETCH_EN streams reads ahead with a one-entry skid register.
//
// state      | meaning
// IDLE       | waiting for start
// FETCH      | read issued (prefetch build: streaming, reads issued as credit allows)
// WAIT       | store access in flight, word captured at the closing edge
// PRESENT    | rk valid, waiting for the consumer
// DONE       | one-cycle done pulse
module magma_key_sched
  import magma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  output logic        key_en,
  output logic [5:0]  key_addr,
  input  logic [31:0] key_data,
  output logic [31:0] rk,
  output logic [4:0]  rk_round,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [4:0]  r_q, r_d;
  logic [31:0] rk_q, rk_d;
  logic [5:0]  key_addr_q;
  logic [4:0]  idx_round;
  logic [2:0]  idx;
  logic        hs;

  magma_round_idx u_round_idx (
    .round_i   (idx_round),
    .decrypt_i (mode_q),
    .idx_o     (idx)
  );

  assign key_addr = key_en ? (KEY_BASE + {3'b000, idx}) : key_addr_q;
  assign rk       = rk_q;
  assign rk_round = r_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      r_q        <= '0;
      rk_q       <= '0;
      key_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      r_q        <= r_d;
      rk_q       <= rk_d;
      key_addr_q <= key_addr;
    end
  end

`ifdef KEY_SCHED_PREFETCH_EN
  logic        rk_valid_q, rk_valid_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_q, skid_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic        ret_q;
  logic [1:0]  occ;

  assign idx_round = rd_cnt_q[4:0];
  assign rk_valid  = rk_valid_q;
  assign hs        = rk_valid_q & rk_ready;

  // Words held or in flight once this cycle's handshake retires; output reg plus skid bound it at two.
  assign occ    = {1'b0, rk_valid_q & ~rk_ready} + {1'b0, skid_vld_q} + {1'b0, ret_q};
  assign key_en = (state_q == ST_FETCH) && !rd_cnt_q[5] && (occ < 2'd2);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    r_d        = r_q;
    rk_d       = rk_q;
    rk_valid_d = rk_valid_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    rd_cnt_d   = rd_cnt_q + 6'(key_en);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          mode_d   = decrypt;
          r_d      = '0;
          rd_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (hs) begin
          rk_valid_d = 1'b0;
          if (r_q == 5'(ROUNDS - 1)) state_d = ST_DONE;
          else                       r_d     = r_q + 5'd1;
        end
        if (hs || !rk_valid_q) begin
          if (skid_vld_q) begin
            rk_d       = skid_q;
            rk_valid_d = 1'b1;
            skid_vld_d = ret_q;
            if (ret_q) skid_d = key_data;
          end else if (ret_q) begin
            rk_d       = key_data;
            rk_valid_d = 1'b1;
          end
        end else if (ret_q) begin
          skid_d     = key_data;
          skid_vld_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      rd_cnt_q   <= '0;
      ret_q      <= 1'b0;
    end else begin
      rk_valid_q <= rk_valid_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      rd_cnt_q   <= rd_cnt_d;
      ret_q      <= key_en;
    end
  end
`else
  assign idx_round = r_q;
  assign rk_valid  = (state_q == ST_PRESENT);
  assign hs        = rk_valid & rk_ready;
  assign key_en    = (state_q == ST_FETCH);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r_d     = r_q;
    rk_d    = rk_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          mode_d  = decrypt;
          r_d     = '0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        rk_d    = key_data;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (hs) begin
          if (r_q == 5'(ROUNDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            r_d     = r_q + 5'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`endif

endmodule

// File: tb/tb_magma_key_sched.sv
// Scoreboard bench for magma_key_sched: a key-store model feeds the DUT and a reference schedule checks every handshake.
module tb_magma_key_sched;

`ifdef KEY_SCHED_PREFETCH_EN
  localparam int GAP = 31;
`else
  localparam int GAP = 93;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        rk_ready = 1'b0;
  logic        key_en;
  logic [5:0]  key_addr;
  logic [31:0] key_data = '0;
  logic [31:0] rk;
  logic [4:0]  rk_round;
  logic        rk_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  magma_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .decrypt  (decrypt),
    .key_en   (key_en),
    .key_addr (key_addr),
    .key_data (key_data),
    .rk       (rk),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [4:0]  round;
    logic [31:0] key;
  } exp_t;

  logic [31:0] kinit [8] = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100,
                             32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF};
  logic [31:0] mem [64];
  logic [31:0] got_key [32];
  exp_t        exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int start_cyc, first_valid, first_hs, last_hs, done_cyc, done_cnt, hs_cnt, en_cnt;

  // Key store: synchronous read, data valid for exactly the cycle after key_en, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    key_data <= key_en ? mem[key_addr] : $urandom();
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       rk_ready = 1'b1;
      1:       rk_ready = ($urandom_range(0, 3) != 0);
      default: rk_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_key(input int r, input bit dec);
    int w;
    if (!dec) w = (r < 24) ? (r % 8) : (7 - (r % 8));
    else      w = (r < 8)  ? r       : (7 - (r % 8));
    return mem[w];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (key_en) en_cnt++;
      if (rk_valid && first_valid < 0) first_valid = cyc;
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake: got round %0d with empty scoreboard", rk_round);
        end else begin
          e = exp_q.pop_front();
          check("rk", rk, e.key);
          check("rk_round", 32'(rk_round), 32'(e.round));
        end
        got_key[rk_round] = rk;
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_rk", rk, 32'h0);
    check("rst_rk_round", 32'(rk_round), 32'h0);
    check("rst_rk_valid", 32'(rk_valid), 32'h0);
    check("rst_key_en", 32'(key_en), 32'h0);
    check("rst_key_addr", 32'(key_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
  endtask

  task automatic start_run(input bit dec);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    decrypt = dec;
    first_valid = -1; first_hs = -1; last_hs = -1;
    done_cyc = -1; done_cnt = 0; hs_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 32; i++) got_key[i] = '0;
    for (int r = 0; r < 32; r++) begin
      e.round = 5'(r);
      e.key   = model_key(r, dec);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    decrypt = ~dec;
    start_cyc = cyc;
    check("busy_after_start", 32'(busy), 32'h1);
  endtask

  task automatic wait_done(input bit timing);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt > 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("run_complete", 32'(ok), 32'h1);
    check("done_pulses", 32'(done_cnt), 32'h1);
    check("done_after_last_hs", 32'(done_cyc), 32'(last_hs + 1));
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("rounds_seen", 32'(hs_cnt), 32'd32);
    check("key_reads", 32'(en_cnt), 32'd32);
    if (timing) begin
      check("first_key_latency", 32'(first_valid - start_cyc), 32'd2);
      check("handshake_span", 32'(last_hs - first_hs), 32'(GAP));
      check("done_time", 32'(done_cyc - start_cyc), 32'(GAP + 3));
    end
    exp_q.delete();
  endtask

  task automatic wait_round(input logic [4:0] rr, input bit need_hs);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rk_valid && rk_round == rr && (!need_hs || rk_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_round", 32'(ok), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    for (int i = 0; i < 8; i++) mem[i] = kinit[i];

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Encrypt, consumer always ready
    ready_mode = 0;
    start_run(1'b0);
    wait_done(1'b1);
    check("enc_r0", got_key[0], 32'hFFEEDDCC);
    check("enc_r7", got_key[7], 32'hFCFDFEFF);
    check("enc_r8", got_key[8], 32'hFFEEDDCC);
    check("enc_r24", got_key[24], 32'hFCFDFEFF);
    check("enc_r31", got_key[31], 32'hFFEEDDCC);

    // Decrypt, consumer always ready
    start_run(1'b1);
    wait_done(1'b1);
    check("dec_r0", got_key[0], 32'hFFEEDDCC);
    check("dec_r7", got_key[7], 32'hFCFDFEFF);
    check("dec_r8", got_key[8], 32'hFCFDFEFF);
    check("dec_r15", got_key[15], 32'hFFEEDDCC);
    check("dec_r31", got_key[31], 32'hFFEEDDCC);

    // Five-cycle stall while round 10 is presented
    start_run(1'b0);
    wait_round(5'd9, 1'b1);
    @(posedge clk);
    #1;
    ready_mode = 2;
    wait_round(5'd10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("stall_rk", rk, model_key(10, 1'b0));
      check("stall_round", 32'(rk_round), 32'd10);
      check("stall_valid", 32'(rk_valid), 32'h1);
      check("stall_key_en", 32'(key_en), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    wait_done(1'b0);

    // Stray start at round 4 must not disturb the run
    start_run(1'b0);
    wait_round(5'd4, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    decrypt = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    decrypt = 1'b0;
    wait_done(1'b1);

    // Asynchronous reset in the middle of a run, then a clean restart
    start_run(1'b1);
    wait_round(5'd20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    start_run(1'b0);
    wait_done(1'b1);
    check("post_reset_r0", got_key[0], 32'hFFEEDDCC);

    // Random keys, random mode, random back-pressure
    ready_mode = 1;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom();
      start_run(1'($urandom_range(0, 1)));
      wait_done(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
